// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the two-port memory arbiter
interface mem_arbiter_if;
  logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_address, mem_data, mem_readData;
  logic        mem_memW, mem_memR;
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_readData,
    output p0_gnt, p0_done, p0_err, p0_rdata, p1_gnt, p1_done, p1_err, p1_rdata,
    output mem_address, mem_data, mem_memW, mem_memR
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_readData,
    input  p0_gnt, p0_done, p0_err, p0_rdata, p1_gnt, p1_done, p1_err, p1_rdata,
    input  mem_address, mem_data, mem_memW, mem_memR
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and sequencer for a single-port registered-read memory
module mem_arbiter #(
  parameter int MEM_SIZE = 32
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic rr, own, we_q, inr_q;
  logic [1:0] gnt, done, err;
  logic [1:0][31:0] rdata;
  logic [31:0] mem_address_q, mem_data_q;
  logic mem_w_q, mem_r_q;
  logic win, w_we, w_inr;
  logic [31:0] w_addr, w_wdata;
  always_comb begin
    win = (bus.p0_req & bus.p1_req) ? rr : bus.p1_req;
    w_we = win ? bus.p1_we : bus.p0_we;
    w_addr = win ? bus.p1_addr : bus.p0_addr;
    w_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    w_inr = w_addr < 32'(MEM_SIZE);
  end
  // memory strobes are set on the capture edge so they are live for the whole ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b0;
      own <= 1'b0;
      we_q <= 1'b0;
      inr_q <= 1'b0;
      gnt <= '0;
      done <= '0;
      err <= '0;
      rdata <= '0;
      mem_address_q <= '0;
      mem_data_q <= '0;
      mem_w_q <= 1'b0;
      mem_r_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.p0_req | bus.p1_req) begin
          state <= ISSUE;
          own <= win;
          rr <= ~win;
          we_q <= w_we;
          inr_q <= w_inr;
          gnt[win] <= 1'b1;
          if (w_inr) begin
            mem_address_q <= w_addr;
            mem_data_q <= w_wdata;
            mem_w_q <= w_we;
            mem_r_q <= ~w_we;
          end
        end
        ISSUE: begin
          gnt <= '0;
          mem_w_q <= 1'b0;
          mem_r_q <= 1'b0;
          if (inr_q && !we_q) state <= RDWAIT;
          else begin
            state <= RESP;
            done[own] <= 1'b1;
            err[own] <= ~inr_q;
          end
        end
        RDWAIT: begin
          state <= RESP;
          done[own] <= 1'b1;
          rdata[own] <= bus.mem_readData;
        end
        default: begin
          state <= IDLE;
          done <= '0;
          err <= '0;
          rdata <= '0;
        end
      endcase
    end
  end
  assign bus.p0_gnt = gnt[0];
  assign bus.p1_gnt = gnt[1];
  assign bus.p0_done = done[0];
  assign bus.p1_done = done[1];
  assign bus.p0_err = err[0];
  assign bus.p1_err = err[1];
  assign bus.p0_rdata = rdata[0];
  assign bus.p1_rdata = rdata[1];
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_memW = mem_w_q;
  assign bus.mem_memR = mem_r_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int MEM_SIZE = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [0:MEM_SIZE-1];
  logic m_rr = 1'b0;
  logic [31:0] mem [0:MEM_SIZE-1];
  logic [31:0] rd_q;
  mem_arbiter_if bus();
  mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // attached memory: synchronous write, registered read, cleared by the shared reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
      rd_q <= '0;
    end else begin
      if (bus.mem_memW) mem[bus.mem_address[4:0]] <= bus.mem_data;
      if (bus.mem_memR) rd_q <= mem[bus.mem_address[4:0]];
    end
  end
  assign bus.mem_readData = rd_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic gnt_of(input bit p);
    return p ? bus.p1_gnt : bus.p0_gnt;
  endfunction
  function automatic logic done_of(input bit p);
    return p ? bus.p1_done : bus.p0_done;
  endfunction
  function automatic logic [31:0] rdata_of(input bit p);
    return p ? bus.p1_rdata : bus.p0_rdata;
  endfunction
  function automatic logic err_of(input bit p);
    return p ? bus.p1_err : bus.p0_err;
  endfunction
  function automatic logic all_zero();
    return ~|{bus.p0_gnt, bus.p0_done, bus.p0_err, bus.p0_rdata, bus.p1_gnt, bus.p1_done,
              bus.p1_err, bus.p1_rdata, bus.mem_address, bus.mem_data, bus.mem_memW, bus.mem_memR};
  endfunction
  task automatic set_port(input bit p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end else begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = '0;
    m_rr = 1'b0;
  endtask
  // one transaction from a lone requester; gl is the expected req-to-gnt distance in cycles
  task automatic txn(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input int gl, input bit drop);
    logic oor, rd_path;
    logic [31:0] erd;
    int n;
    oor = a >= MEM_SIZE;
    rd_path = !we && !oor;
    erd = rd_path ? ref_mem[a[4:0]] : 32'h0;
    if (we && !oor) ref_mem[a[4:0]] = d;
    m_rr = ~p;
    set_port(p, 1'b1, we, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_of(p) && n < 20);
    chk("gnt_latency", n, gl);
    chk("memW", bus.mem_memW, we & !oor);
    chk("memR", bus.mem_memR, !we & !oor);
    if (!oor) chk("mem_address", bus.mem_address, a);
    if (we && !oor) chk("mem_data", bus.mem_data, d);
    if (drop) set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_of(p) && n < 20);
    chk("done_latency", n, rd_path ? 2 : 1);
    chk("rdata", rdata_of(p), erd);
    chk("err", err_of(p), oor);
    chk("other_quiet", {done_of(~p), rdata_of(~p)}, 0);
    if (drop) @(negedge clk);
  endtask
  always @(negedge clk) if (!reset) begin
    chk("strobe_excl", bus.mem_memW & bus.mem_memR, 0);
    chk("strobe_issue", (bus.mem_memW | bus.mem_memR) & ~(bus.p0_gnt | bus.p1_gnt), 0);
    chk("single_owner", (bus.p0_gnt | bus.p0_done) & (bus.p1_gnt | bus.p1_done), 0);
  end
  initial begin
    bit own;
    int n, d;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_zero(), 1);
    reset = 1'b0;
    @(negedge clk);
    txn(0, 1, 5, 32'hDEADBEEF, 1, 1);
    txn(0, 0, 5, 0, 1, 1);
    txn(0, 1, 1, 32'h11, 1, 1);
    txn(1, 1, 2, 32'h22, 1, 1);
    set_port(0, 1, 0, 1, 0);
    set_port(1, 1, 0, 2, 0);
    own = 1'b0;
    n = 0;
    d = 0;
    while (d < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.p0_gnt | bus.p1_gnt) begin
        own = bus.p1_gnt;
        chk("rr_winner", own, m_rr);
        m_rr = ~own;
      end
      if (bus.p0_done | bus.p1_done) begin
        d++;
        chk("rr_rdata", rdata_of(own), ref_mem[own ? 2 : 1]);
        if (d == 4) begin
          set_port(0, 0, 0, 0, 0);
          set_port(1, 0, 0, 0, 0);
        end
      end
    end
    chk("rr_done_count", d, 4);
    @(negedge clk);
    txn(1, 1, 32, 32'h12345678, 1, 1);
    txn(0, 0, 0, 0, 1, 1);
    txn(1, 0, 2, 0, 1, 0);
    txn(1, 0, 2, 0, 2, 0);
    txn(1, 0, 2, 0, 2, 0);
    txn(1, 0, 2, 0, 2, 1);
    txn(0, 1, 7, 32'hCAFE0007, 1, 1);
    set_port(0, 1, 0, 7, 0);
    @(negedge clk);
    chk("rst_gnt", bus.p0_gnt, 1);
    set_port(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", all_zero(), 1);
    reset = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", bus.p0_done, 0);
    end
    txn(1, 0, 7, 0, 1, 1);
    for (int i = 0; i < 1000; i++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (32-bit words, synchronous write, registered read, MEM_SIZE words).
- Shares the memory between requester 0 (core load/store unit) and requester 1 (DMA/debug port) with round-robin priority.
- Range-checks addresses, drives the memory strobes, and returns read data with a done/err handshake.
- Sits between the requesters and the memory instance. It is the only driver of the memory's address/data/memW/memR.

Parameters:
- MEM_SIZE, 32, number of words in the attached memory; valid word addresses are 0..MEM_SIZE-1.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high; same reset as the attached memory
- p0_req  input  1  requester 0 transaction request
- p0_we  input  1  1=write, 0=read
- p0_addr  input  32  word address
- p0_wdata  input  32  write data
- p0_gnt  output  1  one-cycle pulse: request captured
- p0_done  output  1  one-cycle pulse: transaction complete
- p0_rdata  output  32  read data, valid while p0_done=1
- p0_err  output  1  valid with p0_done: address out of range
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata, p1_err: identical to the p0_* ports, for requester 1
- mem_address  output  32  to memory address
- mem_data  output  32  to memory data
- mem_memW  output  1  to memory memW
- mem_memR  output  1  to memory memR
- mem_readData  input  32  from memory readData

Behaviour:
- All outputs registered.
- Reset values: every output 0, state IDLE, round-robin pointer rr=0 (requester 0 has priority).
- Requester rule: hold req/we/addr/wdata stable until gnt is seen. Change or drop req on the edge ending the gnt cycle. A req still high in IDLE starts a new transaction.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE (cycle C0):
  - If any req is high, capture the winner's we/addr/wdata and port id.
  - Winner: the only requester, or requester rr when both request.
  - Set rr <= other port. Next state ISSUE.
  - With no req, rr is unchanged.
- ISSUE (C1):
  - gnt of the owner = 1.
  - If addr < MEM_SIZE: mem_address=addr, mem_data=wdata, and exactly one strobe high (mem_memW=we, mem_memR=!we). Never both strobes.
  - If addr >= MEM_SIZE: no strobe is asserted.
  - Next state: in-range read -> RDWAIT; write or out-of-range -> RESP.
- RDWAIT (C2):
  - Strobes low.
  - mem_readData is valid (memory registered it at end of C1). Latch it.
  - Next state RESP.
- RESP:
  - Owner's done=1.
  - In-range read: rdata = latched data, err=0.
  - Write: rdata=0, err=0 (memory written at end of C1).
  - Out of range: rdata=0, err=1.
  - Next state IDLE.
- Latency from capture edge:
  - gnt: 1 cycle after capture.
  - Write and error done: 2 cycles after capture.
  - Read done: 3 cycles after capture.
- Throughput: one transaction in flight; back-to-back capture possible in the cycle after RESP.
- Only the owner's gnt/done/rdata/err ever toggle. The other port's outputs stay 0.
- Mid-transaction requests from the non-owner are held off and win the next IDLE arbitration if rr points at them.
- Reset mid-operation: next edge forces IDLE, rr=0, all outputs 0. No done is issued for the aborted transaction. Memory contents are cleared by the shared reset.

Test Plan:
- Write then read: p0 write addr 5 data 0xDEADBEEF; p0_gnt at C1, p0_done at C2. Then p0 read addr 5 -> p0_done with p0_rdata=0xDEADBEEF, p0_err=0, 3 cycles after capture.
- Simultaneous requests: p0 and p1 hold reads of addr 1/2 (preloaded 0x11/0x22) continuously. Grants alternate p0,p1,p0,p1 starting with p0 after reset. Each done carries the correct word.
- Out of range: p1 write addr 32 (MEM_SIZE=32) -> p1_done+p1_err at C2, mem_memW and mem_memR never high. A subsequent read of addr 0 returns 0, so memory is unchanged.
- Single requester starvation check: only p1 requests 4 reads back-to-back. Each is granted despite rr, with IDLE-to-capture in the first cycle of IDLE.
- Reset during read: assert reset in RDWAIT. No p0_done, all outputs 0 next cycle. A following p1 read of the prior-written address returns 0.
- Strobe exclusivity: across a random mix of 1000 transactions, assert mem_memW & mem_memR never both 1, and strobes high only in ISSUE.
